// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end: register-address width,
// the canonical NOP encoding and the hazard controller state encoding.
package core_pkg;

  localparam int REG_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DISCARD  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_cnt.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module hazard_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end sequencing controller: resolves EX redirects, load-use hazards and
// instruction-memory wait states into PC / IF-ID / ID-EX controls.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output hz_state_t        dbg_state
);

  localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT - 1);

  hz_state_t  state;
  logic [2:0] lat_cnt;
  logic       lu;
  logic       redirect_acc;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign dbg_state = state;

  always_comb begin
    pc_en        = 1'b1;
    pc_sel       = 1'b0;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    redirect_acc = 1'b0;
    if (!rst) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_redirect) begin
            pc_sel       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            redirect_acc = 1'b1;
          end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        LU_STALL: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        DISCARD: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end
        default: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
      endcase
    end
  end

  // A redirect with no fetch returned leaves a wrong-path word in flight;
  // DISCARD waits for it and drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      lat_cnt <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (ex_redirect) begin
            state <= imem_ready ? RUN : DISCARD;
          end else if (lu && (LOAD_LAT > 1)) begin
            state   <= LU_STALL;
            lat_cnt <= LAT_INIT;
          end
        end
        LU_STALL: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) state <= RUN;
        end
        DISCARD: begin
          if (imem_ready) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  hazard_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (!pc_en),
    .cnt (stall_cnt)
  );

  hazard_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (redirect_acc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations driven from shared inputs,
// directed scenarios plus a randomized run against a cycle-level model.
module tb_hazard_ctrl;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       ex_mem_read = 1'b0, ex_redirect = 1'b0, imem_ready = 1'b1;

  // instance 0: LOAD_LAT=1, 1: LOAD_LAT=3, 2: LOAD_LAT=2 with 4-bit counters
  logic        pc_en_v [3];
  logic        pc_sel_v [3];
  logic        if_id_en_v [3];
  logic        if_id_flush_v [3];
  logic        id_ex_flush_v [3];
  logic [15:0] stall_v [3];
  logic [15:0] flush_v [3];
  logic [15:0] stall_l1, flush_l1, stall_l3, flush_l3;
  logic [3:0]  stall_s, flush_s;
  hz_state_t   st_v [3];
  logic [4:0]  o [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .pc_en(pc_en_v[0]), .pc_sel(pc_sel_v[0]), .if_id_en(if_id_en_v[0]),
    .if_id_flush(if_id_flush_v[0]), .id_ex_flush(id_ex_flush_v[0]),
    .stall_cnt(stall_l1), .flush_cnt(flush_l1), .dbg_state(st_v[0]));

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_l3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .pc_en(pc_en_v[1]), .pc_sel(pc_sel_v[1]), .if_id_en(if_id_en_v[1]),
    .if_id_flush(if_id_flush_v[1]), .id_ex_flush(id_ex_flush_v[1]),
    .stall_cnt(stall_l3), .flush_cnt(flush_l3), .dbg_state(st_v[1]));

  hazard_ctrl #(.LOAD_LAT(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .pc_en(pc_en_v[2]), .pc_sel(pc_sel_v[2]), .if_id_en(if_id_en_v[2]),
    .if_id_flush(if_id_flush_v[2]), .id_ex_flush(id_ex_flush_v[2]),
    .stall_cnt(stall_s), .flush_cnt(flush_s), .dbg_state(st_v[2]));

  assign stall_v[0] = stall_l1;
  assign flush_v[0] = flush_l1;
  assign stall_v[1] = stall_l3;
  assign flush_v[1] = flush_l3;
  assign stall_v[2] = {12'd0, stall_s};
  assign flush_v[2] = {12'd0, flush_s};

  // packed view: {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush}
  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign o[g] = {pc_en_v[g], pc_sel_v[g], if_id_en_v[g], if_id_flush_v[g], id_ex_flush_v[g]};
  end

  localparam logic [4:0] O_RUN   = 5'b10100;
  localparam logic [4:0] O_LU    = 5'b00001;
  localparam logic [4:0] O_REDIR = 5'b11111;
  localparam logic [4:0] O_WAIT  = 5'b00110;
  localparam logic [4:0] O_RST   = 5'b00111;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic redir, input logic rdy);
    @(negedge clk);
    ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_uses_rs1 = u1;
    id_rs2 = rs2; id_uses_rs2 = u2; ex_redirect = redir; imem_ready = rdy;
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ex_mem_read = 1'b0; ex_redirect = 1'b0; imem_ready = 1'b1;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    ex_redirect = 1'b1; imem_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o[k] !== O_RST) begin
        failures++; $display("FAIL reset_outs[%0d] got=%b exp=%b", k, o[k], O_RST);
      end
      checks++;
      if (stall_v[k] !== 16'd0 || flush_v[k] !== 16'd0 || st_v[k] !== RUN) begin
        failures++;
        $display("FAIL reset_state[%0d] got stall=%0d flush=%0d st=%0d exp 0 0 0",
                 k, stall_v[k], flush_v[k], st_v[k]);
      end
    end
    ex_redirect = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic test_lu_lat1();
    do_reset();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1); // lw x5 / add x6,x5,x1
    checks++;
    if (o[0] !== O_LU) begin failures++; $display("FAIL lu1_stall got=%b exp=%b", o[0], O_LU); end
    drive_idle();
    checks++;
    if (o[0] !== O_RUN || stall_v[0] !== 16'd1 || st_v[0] !== RUN) begin
      failures++; $display("FAIL lu1_after got=%b stall=%0d st=%0d exp=%b stall=1 st=0",
                           o[0], stall_v[0], st_v[0], O_RUN);
    end
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (o[0] !== O_RUN) begin failures++; $display("FAIL lu1_x0 got=%b exp=%b", o[0], O_RUN); end
  endtask

  task automatic test_lu_lat3();
    do_reset();
    drive(1'b1, 5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
    checks++;
    if (o[1] !== O_LU) begin failures++; $display("FAIL lu3_c1 got=%b exp=%b", o[1], O_LU); end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); // redirect must be ignored
    checks++;
    if (o[1] !== O_LU || st_v[1] !== LU_STALL) begin
      failures++; $display("FAIL lu3_c2 got=%b st=%0d exp=%b st=1", o[1], st_v[1], O_LU);
    end
    drive_idle();
    checks++;
    if (o[1] !== O_LU) begin failures++; $display("FAIL lu3_c3 got=%b exp=%b", o[1], O_LU); end
    drive_idle();
    checks++;
    if (o[1] !== O_RUN || st_v[1] !== RUN || stall_v[1] !== 16'd3 || flush_v[1] !== 16'd0) begin
      failures++;
      $display("FAIL lu3_end got=%b st=%0d stall=%0d flush=%0d exp=%b st=0 stall=3 flush=0",
               o[1], st_v[1], stall_v[1], flush_v[1], O_RUN);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (o[0] !== O_REDIR) begin failures++; $display("FAIL redir got=%b exp=%b", o[0], O_REDIR); end
    drive_idle();
    checks++;
    if (o[0] !== O_RUN || flush_v[0] !== 16'd1 || st_v[0] !== RUN) begin
      failures++; $display("FAIL redir_after got=%b flush=%0d st=%0d exp=%b flush=1 st=0",
                           o[0], flush_v[0], st_v[0], O_RUN);
    end
  endtask

  task automatic test_discard();
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o[0] !== O_REDIR) begin failures++; $display("FAIL disc_redir got=%b exp=%b", o[0], O_REDIR); end
    for (int i = 0; i < 3; i++) begin
      // second DISCARD cycle also pulses a redirect that must be ignored
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, (i == 1), (i == 2));
      checks++;
      if (o[0] !== O_WAIT || st_v[0] !== DISCARD) begin
        failures++; $display("FAIL disc_c%0d got=%b st=%0d exp=%b st=2", i, o[0], st_v[0], O_WAIT);
      end
    end
    drive_idle();
    checks++;
    if (o[0] !== O_RUN || st_v[0] !== RUN || flush_v[0] !== 16'd1 || stall_v[0] !== 16'd3) begin
      failures++;
      $display("FAIL disc_end got=%b st=%0d flush=%0d stall=%0d exp=%b st=0 flush=1 stall=3",
               o[0], st_v[0], flush_v[0], stall_v[0], O_RUN);
    end
  endtask

  task automatic test_lu_vs_redirect();
    do_reset();
    drive(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (o[1] !== O_REDIR) begin failures++; $display("FAIL prio got=%b exp=%b", o[1], O_REDIR); end
    drive_idle();
    checks++;
    if (st_v[1] !== RUN || o[1] !== O_RUN || flush_v[1] !== 16'd1) begin
      failures++; $display("FAIL prio_after st=%0d got=%b flush=%0d exp st=0 %b flush=1",
                           st_v[1], o[1], flush_v[1], O_RUN);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_idle();
    checks++;
    if (stall_v[2] !== 16'd15) begin failures++; $display("FAIL sat got=%0d exp=15", stall_v[2]); end
    checks++;
    if (stall_v[0] !== 16'd20) begin failures++; $display("FAIL sat_wide got=%0d exp=20", stall_v[0]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    drive_idle();
    checks++;
    if (st_v[1] !== LU_STALL) begin failures++; $display("FAIL areset_pre st=%0d exp=1", st_v[1]); end
    #1 rst = 1'b0;   // well away from any clock edge
    #1;
    checks++;
    if (o[1] !== O_RST || st_v[1] !== RUN || stall_v[1] !== 16'd0) begin
      failures++; $display("FAIL areset got=%b st=%0d stall=%0d exp=%b st=0 stall=0",
                           o[1], st_v[1], stall_v[1], O_RST);
    end
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    checks++;
    if (o[1] !== O_RUN || st_v[1] !== RUN || stall_v[1] !== 16'd0 || flush_v[1] !== 16'd0) begin
      failures++; $display("FAIL areset_rel got=%b st=%0d stall=%0d flush=%0d exp=%b 0 0 0",
                           o[1], st_v[1], stall_v[1], flush_v[1], O_RUN);
    end
  endtask

  // Model: each instance is "free", "N forced stall cycles left", or "waiting
  // to drop one fetch"; counters are plain integers clamped at their maximum.
  task automatic test_random();
    int lat [3] = '{1, 3, 2};
    int cmax [3] = '{65535, 65535, 15};
    int stall_left [3] = '{0, 0, 0};
    bit dropping [3] = '{0, 0, 0};
    int m_stall [3] = '{0, 0, 0};
    int m_flush [3] = '{0, 0, 0};
    logic [4:0] exp;
    bit hit;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
      hit = ex_mem_read && ex_rd != 0 &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (stall_v[k] !== 16'(m_stall[k]) || flush_v[k] !== 16'(m_flush[k])) begin
          failures++; $display("FAIL rnd_cnt[%0d] cyc=%0d got stall=%0d flush=%0d exp %0d %0d",
                               k, c, stall_v[k], flush_v[k], m_stall[k], m_flush[k]);
        end
        if (stall_left[k] > 0) begin
          exp = O_LU; stall_left[k]--;
        end else if (dropping[k]) begin
          exp = O_WAIT; if (imem_ready) dropping[k] = 0;
        end else if (ex_redirect) begin
          exp = O_REDIR; dropping[k] = !imem_ready;
          if (m_flush[k] < cmax[k]) m_flush[k]++;
        end else if (hit) begin
          exp = O_LU; stall_left[k] = lat[k] - 1;
        end else if (!imem_ready) begin
          exp = O_WAIT;
        end else begin
          exp = O_RUN;
        end
        if (!exp[4] && m_stall[k] < cmax[k]) m_stall[k]++;
        checks++;
        if (o[k] !== exp) begin
          failures++; $display("FAIL rnd_outs[%0d] cyc=%0d got=%b exp=%b", k, c, o[k], exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lu_lat1();
    test_lu_lat3();
    test_redirect();
    test_discard();
    test_lu_vs_redirect();
    test_saturate();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
